// File: rtl/demux18_pkg.sv
// Shared constants and state type for the 1-to-8 bit demux / word collector.
package demux18_pkg;

  localparam int WIDTH = 8;
  localparam int SEL_W = 3;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

endpackage

// File: rtl/decoder38_onehot.sv
// Combinational 3-to-8 one-hot decoder; the enable gates every output so the
// result can be used directly as a per-bit write strobe.
module decoder38_onehot
  import demux18_pkg::*;
(
  input  logic [SEL_W-1:0] idx_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/demux18_collector.sv
// Collects single bits into an 8-bit shadow word (addressed or auto-increment)
// and presents each completed word through a valid/ready output register.
module demux18_collector
  import demux18_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [SEL_W-1:0] sel,
  input  logic             auto_inc,
  input  logic             clear,
  output logic [WIDTH-1:0] out_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] written_mask
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;

  logic             accept;
  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] wr_en;
  logic [WIDTH-1:0] shadow_merged;
  logic [WIDTH-1:0] mask_merged;
  logic             complete;

  assign in_ready     = (state_q == COLLECT);
  assign out_valid    = valid_q;
  assign out_word     = word_q;
  assign written_mask = mask_q;

  // clear suppresses the accept so a bit offered alongside it is dropped
  assign accept = in_valid && in_ready && !clear;
  assign idx    = auto_inc ? ptr_q : sel;

  decoder38_onehot u_decoder (
    .idx_i    (idx),
    .en_i     (accept),
    .onehot_o (wr_en)
  );

  assign shadow_merged = (shadow_q & ~wr_en) | (wr_en & {WIDTH{in_bit}});
  assign mask_merged   = mask_q | wr_en;
  assign complete      = accept && (&mask_merged);

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    mask_d   = mask_q;
    ptr_d    = ptr_q;
    word_d   = word_q;
    valid_d  = valid_q;
    if (clear) begin
      state_d  = COLLECT;
      shadow_d = '0;
      mask_d   = '0;
      ptr_d    = '0;
      valid_d  = 1'b0;
    end else if (complete) begin
      state_d  = HOLD;
      word_d   = shadow_merged;
      valid_d  = 1'b1;
      shadow_d = '0;
      mask_d   = '0;
      ptr_d    = '0;
    end else if (accept) begin
      shadow_d = shadow_merged;
      mask_d   = mask_merged;
      ptr_d    = idx + 3'd1;
    end else if (state_q == HOLD && out_ready) begin
      state_d = COLLECT;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= COLLECT;
      shadow_q <= '0;
      mask_q   <= '0;
      ptr_q    <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      mask_q   <= mask_d;
      ptr_q    <= ptr_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_demux18_collector.sv
// Self-checking bench for demux18_collector: directed scenarios plus a random
// soak, all compared against a bit-array reference model of the collector.
module tb_demux18_collector;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic [2:0] sel;
  logic       auto_inc;
  logic       clear;
  logic [7:0] out_word;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] written_mask;

  int checks;
  int errors;

  bit   mBits[8];
  bit   mWritten[8];
  int   mPtr;
  bit   mHold;
  logic [7:0] mWord;

  demux18_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bit       (in_bit),
    .sel          (sel),
    .auto_inc     (auto_inc),
    .clear        (clear),
    .out_word     (out_word),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .written_mask (written_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] modelMask();
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = mWritten[i];
    return m;
  endfunction

  function automatic void modelFlush();
    for (int i = 0; i < 8; i++) begin
      mBits[i]    = 1'b0;
      mWritten[i] = 1'b0;
    end
    mPtr = 0;
  endfunction

  function automatic void modelReset();
    modelFlush();
    mHold = 1'b0;
    mWord = 8'h00;
  endfunction

  // One clock of the collector's rules, evaluated from the inputs held this cycle
  function automatic void modelStep();
    int  idx;
    int  count;
    if (clear) begin
      modelFlush();
      mHold = 1'b0;
    end else if (mHold) begin
      if (out_ready) mHold = 1'b0;
    end else if (in_valid) begin
      idx = auto_inc ? mPtr : int'(sel);
      mBits[idx]    = in_bit;
      mWritten[idx] = 1'b1;
      mPtr = (idx + 1) % 8;
      count = 0;
      for (int i = 0; i < 8; i++) count += int'(mWritten[i]);
      if (count == 8) begin
        for (int i = 0; i < 8; i++) mWord[i] = mBits[i];
        mHold = 1'b1;
        modelFlush();
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idleInputs();
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    sel       = 3'd0;
    auto_inc  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    rst_n = 1'b0;
    modelReset();
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_word !== 8'h00 || written_mask !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_outputs: valid=%b word=%h mask=%h, expected 0/00/00", out_valid, out_word, written_mask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_auto_word();
    logic [7:0] pattern;
    pattern = 8'b0100_1101;
    auto_inc  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bit   = pattern[i];
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_word !== 8'h4D || in_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL auto_word: valid=%b word=%h ready=%b, expected 1/4d/0", out_valid, out_word, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_word !== mWord) begin
      errors++;
      $display("[TB] FAIL auto_word_release: valid=%b ready=%b word=%h, expected 0/1/%h", out_valid, in_ready, out_word, mWord);
    end
  endtask

  task automatic test_addressed();
    logic [7:0] expMask;
    auto_inc  = 1'b0;
    out_ready = 1'b1;
    expMask   = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      in_valid = 1'b1;
      sel      = 3'(i);
      in_bit   = (i == 5);
      tick();
      expMask[i] = 1'b1;
      if (i != 0) begin
        checks++;
        if (written_mask !== expMask) begin
          errors++;
          $display("[TB] FAIL addr_mask_step%0d: got %h expected %h", i, written_mask, expMask);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (out_word !== 8'h20 || out_valid !== 1'b1 || written_mask !== 8'h00) begin
      errors++;
      $display("[TB] FAIL addr_word: word=%h valid=%b mask=%h, expected 20/1/00", out_word, out_valid, written_mask);
    end
    tick();
  endtask

  task automatic test_rewrite();
    int order[9] = '{3, 3, 0, 1, 2, 4, 5, 6, 7};
    bit early;
    auto_inc  = 1'b0;
    out_ready = 1'b1;
    early     = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      sel      = 3'(order[i]);
      in_bit   = (i != 1);
      tick();
      if (i < 8 && out_valid !== 1'b0) early = 1'b1;
    end
    in_valid = 1'b0;
    checks++;
    if (early) begin
      errors++;
      $display("[TB] FAIL rewrite_early: out_valid rose before all 8 positions, expected 0 until last write");
    end
    checks++;
    if (out_word !== 8'hF7 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rewrite_word: word=%h valid=%b, expected f7/1", out_word, out_valid);
    end
    tick();
  endtask

  task automatic test_back_pressure();
    auto_inc  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom_range(0, 1));
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      in_bit = ~in_bit;
      tick();
      checks++;
      if (out_word !== mWord || in_ready !== 1'b0 || out_valid !== 1'b1 || written_mask !== 8'h00) begin
        errors++;
        $display("[TB] FAIL hold_cycle%0d: word=%h ready=%b valid=%b mask=%h, expected %h/0/1/00", c, out_word, in_ready, out_valid, written_mask, mWord);
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release: ready=%b valid=%b, expected 1/0", in_ready, out_valid);
    end
    in_bit = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (written_mask !== 8'h01) begin
      errors++;
      $display("[TB] FAIL ptr_after_release: mask=%h expected 01", written_mask);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_clear();
    auto_inc  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'($urandom_range(0, 1));
      tick();
    end
    clear  = 1'b1;
    in_bit = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (written_mask !== 8'h00 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_flush: mask=%h valid=%b ready=%b, expected 00/0/1", written_mask, out_valid, in_ready);
    end
    in_bit = 1'b0;
    tick();
    checks++;
    if (written_mask !== 8'h01) begin
      errors++;
      $display("[TB] FAIL clear_ptr: mask=%h expected 01", written_mask);
    end
    for (int i = 1; i < 8; i++) begin
      in_bit = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_word !== mWord) begin
      errors++;
      $display("[TB] FAIL clear_fresh_word: valid=%b word=%h, expected 1/%h", out_valid, out_word, mWord);
    end
    tick();
  endtask

  task automatic test_async_reset();
    auto_inc  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_bit   = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checks++;
    if (out_valid !== 1'b0 || out_word !== 8'h00 || written_mask !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset: valid=%b word=%h mask=%h, expected 0/00/00", out_valid, out_word, written_mask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL async_reset_release: ready=%b expected 1", in_ready);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      in_bit    = 1'($urandom_range(0, 1));
      sel       = 3'($urandom_range(0, 7));
      auto_inc  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 2) != 0);
      clear     = 1'($urandom_range(0, 23) == 0);
      tick();
      checks++;
      if (in_ready !== !mHold || out_valid !== mHold || out_word !== mWord || written_mask !== modelMask()) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d: ready=%b valid=%b word=%h mask=%h, expected %b/%b/%h/%h",
                 c, in_ready, out_valid, out_word, written_mask, !mHold, mHold, mWord, modelMask());
      end
    end
    idleInputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    test_reset();
    test_auto_word();
    test_addressed();
    test_rewrite();
    test_back_pressure();
    test_clear();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
